// File: rtl/hazard_ctrl.sv
// Purpose: ID/EX hazard controller: scoreboard-based forwarding, load-use / flag stalls, redirect squash window.
// Latency: stall/issue/pc_sel/fwd are combinational from ID inputs and registered state; flush is registered.
// Backpressure: stall holds PC and IF/ID and injects a bubble into EX; FLUSH squashes IF/ID for BR_PENALTY cycles.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   id_valid, id_opcode, id_rd,
//   id_rs, id_rt, id_cond             decoded fields of the instruction held in ID
//   flags                             registered {N,V,Z} from EX
//   stall, issue, pc_sel, flush       pipeline control
//   fwd_rs, fwd_rt                    0 = register file, k = forward from scoreboard entry k-1
module hazard_ctrl #(
  parameter int RSIZE      = 4,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1,
  parameter int BR_PENALTY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [RSIZE-1:0] id_rd,
  input  logic [RSIZE-1:0] id_rs,
  input  logic [RSIZE-1:0] id_rt,
  input  logic [2:0]       id_cond,
  input  logic [2:0]       flags,
  output logic             stall,
  output logic             issue,
  output logic             pc_sel,
  output logic             flush,
  output logic [2:0]       fwd_rs,
  output logic [2:0]       fwd_rt
);

  typedef struct packed {
    logic             vld;
    logic [RSIZE-1:0] rd;
    logic             ld;
    logic             fl;
  } sb_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [2:0] BR_PEN3 = 3'(BR_PENALTY);

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  sb_t [FWD_DEPTH-1:0]    sb_q;
  sb_t                    sb_new;

  // ---------------------------------------------------------------------
  // Opcode classes
  // ---------------------------------------------------------------------
  logic reads_rs, reads_rt, reads_rd, writes_rd, is_load, sets_fl, is_br;
  logic cond_true, redirect;
  logic flag_n, flag_v, flag_z;

  assign flag_n = flags[2];
  assign flag_v = flags[1];
  assign flag_z = flags[0];

  assign reads_rs  = (id_opcode <= 4'd9);
  assign reads_rt  = (id_opcode <= 4'd3);
  assign reads_rd  = (id_opcode == 4'd9) | (id_opcode == 4'd14) | (id_opcode == 4'd15);
  assign writes_rd = (id_opcode <= 4'd8) | (id_opcode == 4'd10) | (id_opcode == 4'd11) |
                     (id_opcode == 4'd13);
  assign is_load   = (id_opcode == 4'd8);
  assign sets_fl   = (id_opcode <= 4'd7);
  assign is_br     = (id_opcode == 4'd12);

  always_comb begin
    cond_true = 1'b1;
    case (id_cond)
      3'd0:    cond_true = flag_z;
      3'd1:    cond_true = ~flag_z;
      3'd2:    cond_true = ~flag_z & ~flag_n;
      3'd3:    cond_true = flag_n;
      3'd4:    cond_true = flag_z | (~flag_z & ~flag_n);
      3'd5:    cond_true = flag_z | flag_n;
      3'd6:    cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  assign redirect = (is_br & cond_true) | (id_opcode == 4'd13) | (id_opcode == 4'd14) |
                    (id_opcode == 4'd15);

  // ---------------------------------------------------------------------
  // Forwarding lookup: youngest matching entry wins. Result bit 3 flags a
  // load whose data is not yet forwardable; its forward index reads 0.
  // ---------------------------------------------------------------------
  function automatic logic [3:0] lookup(input logic [RSIZE-1:0] src,
                                        input logic used,
                                        input sb_t [FWD_DEPTH-1:0] sb);
    logic       hit;
    logic [3:0] res;
    hit = 1'b0;
    res = '0;
    if (used && (src != '0)) begin
      for (int i = 0; i < FWD_DEPTH; i++) begin
        if (!hit && sb[i].vld && (sb[i].rd == src)) begin
          hit = 1'b1;
          if (sb[i].ld && (i < LOAD_LAT)) res = 4'b1000;
          else                            res = {1'b0, 3'(i + 1)};
        end
      end
    end
    return res;
  endfunction

  logic [3:0]       rs_res, rt_res;
  logic [RSIZE-1:0] rt_src;
  logic             rt_used;
  logic             ld_haz, fl_haz;

  // Stores, JR and EXEC read rd as data; it travels on the rt forwarding path.
  assign rt_src  = reads_rd ? id_rd : id_rt;
  assign rt_used = id_valid & (reads_rd | reads_rt);

  assign rs_res = lookup(id_rs, id_valid & reads_rs, sb_q);
  assign rt_res = lookup(rt_src, rt_used, sb_q);

  assign fwd_rs = rs_res[2:0];
  assign fwd_rt = rt_res[2:0];

  assign ld_haz = rs_res[3] | rt_res[3];
  // The branch must see flags from the instruction now in EX, which are not
  // registered yet; wait one cycle.
  assign fl_haz = is_br & sb_q[0].fl;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    issue   = 1'b0;
    pc_sel  = 1'b0;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        if (id_valid) begin
          stall = ld_haz | fl_haz;
          issue = ~stall;
          if (issue && redirect) begin
            pc_sel = 1'b1;
            if (BR_PENALTY > 0) begin
              state_d = FLUSH;
              cnt_d   = BR_PEN3;
            end
          end
        end
      end
      FLUSH: begin
        flush = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Anything not issued (stall, flush, idle) enters EX as a bubble.
  always_comb begin
    sb_new = '0;
    if (issue) begin
      sb_new.vld = writes_rd & (id_rd != '0);
      sb_new.rd  = id_rd;
      sb_new.ld  = is_load;
      sb_new.fl  = sets_fl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_q[0] <= sb_new;
      for (int i = 1; i < FWD_DEPTH; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: self-checking bench for hazard_ctrl: directed scenarios, then randomized traffic against a reference model.
// Latency: outputs sampled 1 time unit after the falling edge; reference model advances on each rising edge.
// Backpressure: reference model tracks stalls and the flush window directly from the opcode rules.
module tb_hazard_ctrl;

  localparam int RS = 4;
  localparam int FD = 2;
  localparam int LL = 1;
  localparam int BP = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [3:0]    id_opcode;
  logic [RS-1:0] id_rd, id_rs, id_rt;
  logic [2:0]    id_cond;
  logic [2:0]    flags;
  logic          stall, issue, pc_sel, flush;
  logic [2:0]    fwd_rs, fwd_rt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .RSIZE(RS), .FWD_DEPTH(FD), .LOAD_LAT(LL), .BR_PENALTY(BP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_cond(id_cond), .flags(flags),
    .stall(stall), .issue(issue), .pc_sel(pc_sel), .flush(flush),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: history of what entered EX, newest first, plus the
  // number of squash cycles still owed.
  typedef struct {
    bit vld;
    int rd;
    bit ld;
    bit fl;
  } ent_t;

  ent_t hist[$];
  int   flush_left;
  bit   e_stall, e_issue, e_pcsel, e_flush;
  int   e_fwd_rs, e_fwd_rt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    ent_t e;
    e = '{vld: 1'b0, rd: 0, ld: 1'b0, fl: 1'b0};
    hist.delete();
    for (int k = 0; k < FD; k++) hist.push_back(e);
    flush_left = 0;
  endfunction

  function automatic void lookup(input int src, input bit used, output int fwd, output bit haz);
    fwd = 0;
    haz = 1'b0;
    if (!used || src == 0) return;
    for (int k = 0; k < FD; k++) begin
      if (hist[k].vld && hist[k].rd == src) begin
        if (hist[k].ld && k < LL) haz = 1'b1;
        else                      fwd = k + 1;
        return;
      end
    end
  endfunction

  function automatic void predict();
    int  op;
    bit  use_rs, use_rt, rd_data, ct, redir, hz_rs, hz_rt, run;
    bit  n, v, z;
    int  rt_src;
    op      = int'(id_opcode);
    n       = flags[2];
    v       = flags[1];
    z       = flags[0];
    rd_data = (op == 9 || op == 14 || op == 15);
    use_rs  = id_valid && op <= 9;
    use_rt  = id_valid && (op <= 3 || rd_data);
    rt_src  = rd_data ? int'(id_rd) : int'(id_rt);
    lookup(int'(id_rs), use_rs, e_fwd_rs, hz_rs);
    lookup(rt_src, use_rt, e_fwd_rt, hz_rt);
    case (int'(id_cond))
      0:       ct = z;
      1:       ct = !z;
      2:       ct = !z && !n;
      3:       ct = n;
      4:       ct = z || (!z && !n);
      5:       ct = z || n;
      6:       ct = v;
      default: ct = 1'b1;
    endcase
    redir   = (op == 12 && ct) || op >= 13;
    run     = (flush_left == 0);
    e_stall = id_valid && run && (hz_rs || hz_rt || (op == 12 && hist[0].fl));
    e_issue = id_valid && run && !e_stall;
    e_pcsel = e_issue && redir;
    e_flush = !run;
  endfunction

  function automatic void advance();
    ent_t e;
    int   op;
    op = int'(id_opcode);
    e  = '{vld: 1'b0, rd: 0, ld: 1'b0, fl: 1'b0};
    if (e_issue) begin
      e.vld = (op <= 8 || op == 10 || op == 11 || op == 13) && id_rd != 0;
      e.rd  = int'(id_rd);
      e.ld  = (op == 8);
      e.fl  = (op <= 7);
    end
    hist.push_front(e);
    void'(hist.pop_back());
    if (flush_left > 0) flush_left--;
    else if (e_pcsel)   flush_left = BP;
  endfunction

  task automatic drive(input string tag, input bit v, input int op, input int rd,
                       input int rs, input int rt, input int cond, input int fl);
    id_valid  = v;
    id_opcode = 4'(op);
    id_rd     = RS'(rd);
    id_rs     = RS'(rs);
    id_rt     = RS'(rt);
    id_cond   = 3'(cond);
    flags     = 3'(fl);
    #1;
    predict();
    chk({tag, ".stall"},  32'(stall),  32'(e_stall));
    chk({tag, ".issue"},  32'(issue),  32'(e_issue));
    chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(e_pcsel));
    chk({tag, ".flush"},  32'(flush),  32'(e_flush));
    chk({tag, ".fwd_rs"}, 32'(fwd_rs), 32'(e_fwd_rs));
    chk({tag, ".fwd_rt"}, 32'(fwd_rt), 32'(e_fwd_rt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) advance();
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    model_reset();
    drive("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.stall_c", 32'(stall), 0);
    chk("reset.flush_c", 32'(flush), 0);
    tick();
    rst_n = 1'b1;

    // ADD r3 then SUB r4,r3,r3 then ADD r5,r3,r0
    drive("add_r3", 1, 0, 3, 1, 2, 0, 0);
    chk("add_r3.issue_c", 32'(issue), 1);
    tick();
    drive("sub_r3r3", 1, 1, 4, 3, 3, 0, 0);
    chk("sub_r3r3.fwd_rs_c", 32'(fwd_rs), 1);
    chk("sub_r3r3.fwd_rt_c", 32'(fwd_rt), 1);
    chk("sub_r3r3.stall_c", 32'(stall), 0);
    tick();
    drive("add_r3_age2", 1, 0, 5, 3, 0, 0, 0);
    chk("add_r3_age2.fwd_rs_c", 32'(fwd_rs), 2);
    chk("add_r3_age2.fwd_rt_c", 32'(fwd_rt), 0);
    tick();

    // LW r5 then ADD r6,r5,r1: one-cycle load-use stall
    drive("lw_r5", 1, 8, 5, 1, 0, 0, 0);
    tick();
    drive("ld_use", 1, 0, 6, 5, 1, 0, 0);
    chk("ld_use.stall_c", 32'(stall), 1);
    chk("ld_use.fwd_rs_c", 32'(fwd_rs), 0);
    chk("ld_use.issue_c", 32'(issue), 0);
    tick();
    drive("ld_use2", 1, 0, 6, 5, 1, 0, 0);
    chk("ld_use2.stall_c", 32'(stall), 0);
    chk("ld_use2.fwd_rs_c", 32'(fwd_rs), 2);
    chk("ld_use2.issue_c", 32'(issue), 1);
    tick();

    // SUB r1,r2,r2 then B cond=0: flag stall, then taken on Z=1
    drive("sub_fl", 1, 1, 1, 2, 2, 0, 0);
    tick();
    drive("br_fl", 1, 12, 0, 0, 0, 0, 0);
    chk("br_fl.stall_c", 32'(stall), 1);
    tick();
    drive("br_take", 1, 12, 0, 0, 0, 0, 1);
    chk("br_take.pc_sel_c", 32'(pc_sel), 1);
    chk("br_take.issue_c", 32'(issue), 1);
    tick();
    for (int k = 0; k < BP; k++) begin
      drive("flush_win", 1, 0, 2, 1, 1, 0, 0);
      chk("flush_win.flush_c", 32'(flush), 1);
      chk("flush_win.issue_c", 32'(issue), 0);
      tick();
    end

    // B cond=6 with V=0: not taken
    drive("br_nt", 1, 12, 0, 0, 0, 6, 0);
    chk("br_nt.pc_sel_c", 32'(pc_sel), 0);
    chk("br_nt.issue_c", 32'(issue), 1);
    tick();
    drive("add_r7", 1, 0, 7, 1, 1, 0, 0);
    chk("add_r7.flush_c", 32'(flush), 0);
    tick();
    drive("idle", 0, 0, 0, 0, 0, 0, 0);
    tick();

    // JR r7, written two cycles earlier
    drive("jr_r7", 1, 14, 7, 0, 0, 0, 0);
    chk("jr_r7.fwd_rt_c", 32'(fwd_rt), 2);
    chk("jr_r7.pc_sel_c", 32'(pc_sel), 1);
    tick();
    drive("jr_fl1", 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive("jr_fl2", 0, 0, 0, 0, 0, 0, 0);
    chk("jr_fl2.flush_c", 32'(flush), 1);

    // Reset during second flush cycle
    rst_n = 1'b0;
    model_reset();
    drive("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid.flush_c", 32'(flush), 0);
    tick();
    rst_n = 1'b1;

    // Writes to r0 never forward
    drive("add_r0", 1, 0, 0, 1, 1, 0, 0);
    chk("add_r0.issue_c", 32'(issue), 1);
    tick();
    drive("rd_r0", 1, 1, 2, 0, 0, 0, 0);
    chk("rd_r0.fwd_rs_c", 32'(fwd_rs), 0);
    chk("rd_r0.fwd_rt_c", 32'(fwd_rt), 0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        drive("rand_rst", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
      end else begin
        drive("rand",
              $urandom_range(0, 9) != 0,
              int'($urandom_range(0, 15)),
              int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)));
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 16-bit, 16-opcode core. It sits between decode (ID) and execute (EX). It keeps a scoreboard of in-flight destination registers and from it selects operand forwarding per source. It stalls decode on load-use and flag-before-branch hazards, and sequences the redirect/squash window after taken branches and jumps. It replaces the purely combinational forwarding/branch logic with a clocked unit of configurable forwarding depth, load latency and branch penalty.

## Interface
- RSIZE, 4: register address width.
- FWD_DEPTH, 2: in-flight stages tracked for forwarding (1..4); entry 0 = instruction in EX.
- LOAD_LAT, 1: cycles after EX before load data is forwardable (0..FWD_DEPTH-1).
- BR_PENALTY, 1: fetch slots squashed after a redirect (0..7).

Ports (clock and reset first):
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  4  opcode [15:12].
- id_rd, id_rs, id_rt  in  RSIZE  register fields.
- id_cond  in  3  branch condition (B only).
- flags  in  3  registered {N,V,Z} from EX.
- stall  out  1  hold PC and IF/ID; EX receives a bubble.
- issue  out  1  ID instruction advances into EX this cycle.
- pc_sel  out  1  take redirect target this cycle.
- flush  out  1  squash the instruction in IF/ID.
- fwd_rs, fwd_rt  out  3  0 = register file; k = forward from scoreboard entry k-1.

## Operation
- Decode classes:
  - Reads rs: opcodes 0–9.
  - Reads rt: opcodes 0–3.
  - Reads rd as data: 9 (SW), 14 (JR), 15 (EXEC).
  - Writes rd: 0–8, 10, 11, 13.
  - Load: 8.
  - Sets flags: 0–7.
  - Redirect: 12 with condition true, 13, 14, 15.
- Condition decode (id_cond → true when):
  - 0: Z.
  - 1: !Z.
  - 2: !Z&!N.
  - 3: N.
  - 4: Z|(!Z&!N).
  - 5: Z|N.
  - 6: V.
  - 7: 1.
- Scoreboard: FWD_DEPTH entries {vld, rd, ld, fl}, shifting 0→1→… every cycle.
  - Entry 0 loads {writes_rd & rd≠0, rd, is_load, sets_flags} when issue=1.
  - Otherwise entry 0 loads all-zero (bubble).
- Forwarding: for each used source, scan entries 0..FWD_DEPTH-1 in order.
  - Select the first entry with vld and matching rd: fwd = index+1.
  - If that entry has ld=1 and index<LOAD_LAT, it is a load-use hazard; fwd reads 0.
  - No match, unused source, or source register 0: fwd=0.
  - The rd-as-data read for opcodes 9/14/15 drives fwd_rt.
- Hazards, evaluated only in state RUN with id_valid=1:
  - ld_haz: any used source hits a load-use entry.
  - fl_haz: opcode 12 and entry 0 has fl=1.
  - stall = ld_haz | fl_haz.
- issue = id_valid & state==RUN & !stall.
- FSM, states RUN and FLUSH, with 3-bit counter cnt:
  - RUN, issue with a redirect-class instruction: pc_sel=1.
    - BR_PENALTY>0: go to FLUSH, cnt=BR_PENALTY.
    - BR_PENALTY=0: stay in RUN.
  - FLUSH: flush=1, issue=0, stall=0, bubble enters the scoreboard, cnt decrements.
    - Returns to RUN on the cycle cnt reaches 1.
- Branch not taken: no redirect, no flush; the branch issues normally.

## Timing
- Reset (async assert, sync release):
  - State RUN, cnt=0, all scoreboard entries invalid.
  - Outputs: stall=0, issue=0, pc_sel=0, flush=0, fwd_rs=fwd_rt=0.
- stall, issue, pc_sel and fwd_* are combinational from ID inputs and registered state; valid in the same cycle.
- flush is decoded from the registered state: it asserts the cycle after pc_sel and lasts exactly BR_PENALTY cycles.
- A load-use stall lasts LOAD_LAT−index cycles. A flag stall lasts exactly 1 cycle, after which the branch resolves on the new flags.
- When ld_haz and fl_haz coincide, they are a single stall; the instruction re-evaluates each cycle.
- id_valid=0: no stall, no issue, bubble shifted.
- Reset asserted mid-FLUSH or mid-stall: immediate return to the reset values. No pending redirect survives.
- Priority: reset > FLUSH > stall > issue.

## Test plan
- ADD r3 issued, then SUB r4,r3,r3 next cycle → fwd_rs=fwd_rt=1, stall=0. Third instruction reading r3 → fwd=2.
- LW r5 (LOAD_LAT=1), then ADD r6,r5,r1 → stall=1 for one cycle. Next cycle fwd_rs=2, issue=1.
- SUB r1,r2,r2, then B cond=0 → stall=1 for 1 cycle. With flags=001 next cycle: pc_sel=1, then flush=1 for BR_PENALTY cycles.
- B cond=7 with BR_PENALTY=3 → pc_sel=1 one cycle, flush=1 for exactly 3 cycles, issue=0 throughout. B cond=6 with V=0 → no redirect.
- JR r7 with r7 written two cycles earlier → fwd_rt=2. Any instruction writing r0 → never matches, fwd=0.
- rst_n low during 2nd FLUSH cycle → flush=0 and state RUN immediately; scoreboard empty after release.
